// File: rtl/router_pkg.sv
// router_pkg: packet layout, node addresses and helpers shared by the router, its local NI and benches
// Contents: PKT_W, field bit positions, NODE_* addresses, rx_word_t ejection word, build_pkt()
package router_pkg;

    localparam int PKT_W = 40;

    localparam int MARK_BIT = 39;
    localparam int DST_HI   = 38;
    localparam int DST_LO   = 37;
    localparam int SRC_HI   = 36;
    localparam int SRC_LO   = 35;
    localparam int SEQ_HI   = 34;
    localparam int SEQ_LO   = 32;
    localparam int PAY_HI   = 31;
    localparam int PAY_LO   = 0;

    localparam logic [1:0] NODE_0 = 2'd0;
    localparam logic [1:0] NODE_1 = 2'd1;
    localparam logic [1:0] NODE_2 = 2'd2;
    localparam logic [1:0] NODE_3 = 2'd3;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] payload;
    } rx_word_t;

    // The marker bit guarantees a real packet is never all-zero, which the
    // router uses as its "no packet" encoding.
    function automatic logic [PKT_W-1:0] build_pkt(
        input logic [1:0]  dst,
        input logic [1:0]  src,
        input logic [2:0]  seq,
        input logic [31:0] payload
    );
        return {1'b1, dst, src, seq, payload};
    endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// ni_rx_fifo: synchronous first-word-fall-through FIFO with occupancy output
// Ports: clk, rst_n (async, active-high reset), push/din, pop, dout (head word),
//        empty, full, occ (number of stored words)
module ni_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic             wr, rd;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == (AW+1)'(DEPTH));
    assign occ   = occ_q;
    assign dout  = mem_q[rptr_q];

    // A push into a full FIFO is still taken when a pop frees the head slot
    // in the same cycle.
    always_comb begin
        rd     = pop && !empty;
        wr     = push && (!full || rd);
        mem_d  = mem_q;
        if (wr) mem_d[wptr_q] = din;
        wptr_d = wptr_q + AW'(wr);
        rptr_d = rptr_q + AW'(rd);
        occ_d  = occ_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/router_local_ni.sv
// router_local_ni: local network interface sitting on a router's local port
// Ports:
//   clk, rst_n (async, active-high reset)
//   injection: tx_valid/tx_dst/tx_payload/tx_ready from the core;
//              wr_en_local/wdata_local/full_local towards the router local FIFO
//   ejection:  data_to_local/wr_next_local_en/next_full_local from the router;
//              rx_valid/rx_src/rx_payload/rx_ready towards the core
//   status:    tx_count, rx_count (wrapping), drop_count (saturating), seq_err (sticky)
module router_local_ni
    import router_pkg::*;
#(
    parameter logic [1:0] LOCAL_ID = NODE_2,
    parameter int         RX_DEPTH = 8,
    parameter int         WD       = PKT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_valid,
    input  logic [1:0]    tx_dst,
    input  logic [31:0]   tx_payload,
    output logic          tx_ready,
    output logic          wr_en_local,
    output logic [WD-1:0] wdata_local,
    input  logic          full_local,
    input  logic [WD-1:0] data_to_local,
    input  logic          wr_next_local_en,
    output logic          next_full_local,
    output logic          rx_valid,
    output logic [1:0]    rx_src,
    output logic [31:0]   rx_payload,
    input  logic          rx_ready,
    output logic [15:0]   tx_count,
    output logic [15:0]   rx_count,
    output logic [7:0]    drop_count,
    output logic          seq_err
);

    localparam int AW = $clog2(RX_DEPTH);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic          state_q, state_d;
    logic [WD-1:0] wdata_q, wdata_d;
    logic [2:0]    tx_seq_q [4];
    logic [2:0]    tx_seq_d [4];
    logic [2:0]    rx_exp_q [4];
    logic [2:0]    rx_exp_d [4];
    logic [15:0]   tx_count_q, tx_count_d;
    logic [15:0]   rx_count_q, rx_count_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic          seq_err_q, seq_err_d;

    logic          accept;
    logic [1:0]    in_src;
    logic [2:0]    in_seq;
    logic          rx_good, rx_pop, rx_push, rx_drop;
    logic          fifo_empty, fifo_full;
    logic [AW:0]   fifo_occ;
    rx_word_t      fifo_din, fifo_dout;

    // ---------------- injection ----------------
    // Only two states, so "SEND && !full_local" collapses to "!full_local".
    assign tx_ready    = !rst_n && (state_q == ST_IDLE || !full_local);
    assign wr_en_local = (state_q == ST_SEND) && !full_local;
    assign accept      = tx_valid && tx_ready;
    assign wdata_local = wdata_q;
    assign tx_count    = tx_count_q;

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        tx_seq_d   = tx_seq_q;
        tx_count_d = tx_count_q + 16'(wr_en_local);
        if (accept) begin
            state_d          = ST_SEND;
            wdata_d          = build_pkt(tx_dst, LOCAL_ID, tx_seq_q[tx_dst], tx_payload);
            tx_seq_d[tx_dst] = tx_seq_q[tx_dst] + 3'd1;
        end else if (wr_en_local) begin
            state_d = ST_IDLE;
            wdata_d = '0;
        end
    end

    // ---------------- ejection ----------------
    assign in_src   = data_to_local[SRC_HI:SRC_LO];
    assign in_seq   = data_to_local[SEQ_HI:SEQ_LO];
    assign rx_good  = wr_next_local_en && data_to_local[MARK_BIT] &&
                      (data_to_local[DST_HI:DST_LO] == LOCAL_ID);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = rx_good && (!fifo_full || rx_pop);
    assign rx_drop  = wr_next_local_en && !rx_push;
    assign fifo_din = '{src: in_src, payload: data_to_local[PAY_HI:PAY_LO]};

    assign rx_valid        = !fifo_empty;
    assign rx_src          = fifo_dout.src;
    assign rx_payload      = fifo_dout.payload;
    // Two spare slots cover the words already in flight while the router
    // registers the stall.
    assign next_full_local = (fifo_occ >= (AW+1)'(RX_DEPTH - 2));
    assign rx_count        = rx_count_q;
    assign drop_count      = drop_count_q;
    assign seq_err         = seq_err_q;

    // The expected sequence resyncs on every addressed packet, even one lost
    // to a full buffer, so a single gap raises seq_err only once.
    always_comb begin
        rx_exp_d     = rx_exp_q;
        seq_err_d    = seq_err_q;
        rx_count_d   = rx_count_q + 16'(rx_push);
        drop_count_d = (rx_drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
        if (rx_good) begin
            seq_err_d        = seq_err_q || (in_seq != rx_exp_q[in_src]);
            rx_exp_d[in_src] = in_seq + 3'd1;
        end
    end

    ni_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH ($bits(rx_word_t))
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (fifo_din),
        .pop   (rx_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .occ   (fifo_occ)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            wdata_q      <= '0;
            tx_count_q   <= '0;
            rx_count_q   <= '0;
            drop_count_q <= '0;
            seq_err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tx_seq_q[i] <= '0;
                rx_exp_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wdata_q      <= wdata_d;
            tx_seq_q     <= tx_seq_d;
            rx_exp_q     <= rx_exp_d;
            tx_count_q   <= tx_count_d;
            rx_count_q   <= rx_count_d;
            drop_count_q <= drop_count_d;
            seq_err_q    <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_router_local_ni.sv
// tb_router_local_ni: directed self-checking bench for router_local_ni
// One task per scenario; inputs change 1 ns after the rising edge and outputs
// are checked in that same quiet window.
module tb_router_local_ni;
    import router_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid;
    logic [1:0]  tx_dst;
    logic [31:0] tx_payload;
    logic        tx_ready;
    logic        wr_en_local;
    logic [39:0] wdata_local;
    logic        full_local;
    logic [39:0] data_to_local;
    logic        wr_next_local_en;
    logic        next_full_local;
    logic        rx_valid;
    logic [1:0]  rx_src;
    logic [31:0] rx_payload;
    logic        rx_ready;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [7:0]  drop_count;
    logic        seq_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    router_local_ni #(.LOCAL_ID(2'b10), .RX_DEPTH(8), .WD(40)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tx_valid         (tx_valid),
        .tx_dst           (tx_dst),
        .tx_payload       (tx_payload),
        .tx_ready         (tx_ready),
        .wr_en_local      (wr_en_local),
        .wdata_local      (wdata_local),
        .full_local       (full_local),
        .data_to_local    (data_to_local),
        .wr_next_local_en (wr_next_local_en),
        .next_full_local  (next_full_local),
        .rx_valid         (rx_valid),
        .rx_src           (rx_src),
        .rx_payload       (rx_payload),
        .rx_ready         (rx_ready),
        .tx_count         (tx_count),
        .rx_count         (rx_count),
        .drop_count       (drop_count),
        .seq_err          (seq_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_valid = 1'b0; tx_dst = '0; tx_payload = '0; full_local = 1'b0;
        data_to_local = '0; wr_next_local_en = 1'b0; rx_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
    endtask

    task automatic push_rx(input logic [39:0] w);
        data_to_local = w;
        wr_next_local_en = 1'b1;
        tick();
        wr_next_local_en = 1'b0;
        data_to_local = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tx_valid = 1'b1; tx_dst = 2'd0; tx_payload = 32'h1;
        tick();
        tx_valid = 1'b0;
        tick();
        push_rx(40'h80_0000_0000);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; full_local = 1'b1;
        tick();
        total_cnt++; if (tx_count !== 16'd1) $display("FAIL pre_reset tx_count got %0d want 1", tx_count); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (wr_en_local !== 1'b0) $display("FAIL reset wr_en_local got %0b want 0", wr_en_local); else pass_cnt++;
        total_cnt++; if (wdata_local !== 40'h0) $display("FAIL reset wdata_local got %h want 0", wdata_local); else pass_cnt++;
        total_cnt++; if (tx_count !== 16'd0) $display("FAIL reset tx_count got %0d want 0", tx_count); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL reset drop_count got %0d want 0", drop_count); else pass_cnt++;
        total_cnt++; if (rx_count !== 16'd0) $display("FAIL reset rx_count got %0d want 0", rx_count); else pass_cnt++;
        total_cnt++; if (tx_ready !== 1'b0) $display("FAIL reset tx_ready_in_reset got %0b want 0", tx_ready); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0 || next_full_local !== 1'b0 || seq_err !== 1'b0)
            $display("FAIL reset rx_flags got %0b%0b%0b want 000", rx_valid, next_full_local, seq_err); else pass_cnt++;
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset tx_ready_after got %0b want 1", tx_ready); else pass_cnt++;
        full_local = 1'b0;
    endtask

    task automatic test_tx_back_to_back();
        do_reset();
        tx_valid = 1'b1; tx_dst = 2'd1; tx_payload = 32'hDEADBEEF;
        total_cnt++; if (tx_ready !== 1'b1) $display("FAIL b2b tx_ready got %0b want 1", tx_ready); else pass_cnt++;
        tick();
        total_cnt++; if (wr_en_local !== 1'b1) $display("FAIL b2b wr_en_1 got %0b want 1", wr_en_local); else pass_cnt++;
        total_cnt++; if (wdata_local !== 40'hB0DEADBEEF) $display("FAIL b2b wdata_1 got %h want b0deadbeef", wdata_local); else pass_cnt++;
        tx_payload = 32'h00000002;
        tick();
        tx_valid = 1'b0;
        total_cnt++; if (wr_en_local !== 1'b1) $display("FAIL b2b wr_en_2 got %0b want 1", wr_en_local); else pass_cnt++;
        total_cnt++; if (wdata_local !== 40'hB100000002) $display("FAIL b2b wdata_2 got %h want b100000002", wdata_local); else pass_cnt++;
        tick();
        total_cnt++; if (tx_count !== 16'd2) $display("FAIL b2b tx_count got %0d want 2", tx_count); else pass_cnt++;
        total_cnt++; if (wr_en_local !== 1'b0 || wdata_local !== 40'h0)
            $display("FAIL b2b idle got wr_en=%0b wdata=%h want 0/0", wr_en_local, wdata_local); else pass_cnt++;
    endtask

    task automatic test_tx_backpressure();
        do_reset();
        tx_valid = 1'b1; tx_dst = 2'd3; tx_payload = 32'h12345678; full_local = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (wr_en_local !== 1'b0) $display("FAIL bp wr_en cyc%0d got %0b want 0", i, wr_en_local); else pass_cnt++;
            total_cnt++; if (wdata_local !== 40'hF012345678) $display("FAIL bp wdata cyc%0d got %h want f012345678", i, wdata_local); else pass_cnt++;
            total_cnt++; if (tx_ready !== 1'b0) $display("FAIL bp tx_ready cyc%0d got %0b want 0", i, tx_ready); else pass_cnt++;
            tick();
        end
        full_local = 1'b0;
        #1;
        total_cnt++; if (wr_en_local !== 1'b1) $display("FAIL bp wr_en_release got %0b want 1", wr_en_local); else pass_cnt++;
        tick();
        total_cnt++; if (tx_count !== 16'd1) $display("FAIL bp tx_count got %0d want 1", tx_count); else pass_cnt++;
    endtask

    task automatic test_rx_filter();
        do_reset();
        push_rx(40'hC000000001);
        push_rx(40'hA000000005);
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL filt rx_valid got %0b want 1", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_src !== 2'd0) $display("FAIL filt rx_src got %0d want 0", rx_src); else pass_cnt++;
        total_cnt++; if (rx_payload !== 32'd1) $display("FAIL filt rx_payload got %h want 1", rx_payload); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd1) $display("FAIL filt drop_count got %0d want 1", drop_count); else pass_cnt++;
        total_cnt++; if (rx_count !== 16'd1) $display("FAIL filt rx_count got %0d want 1", rx_count); else pass_cnt++;
    endtask

    task automatic test_rx_full();
        logic [31:0] exp_pay [8];
        exp_pay = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd10};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                total_cnt++; if (next_full_local !== 1'b0) $display("FAIL full nf_at5 got %0b want 0", next_full_local); else pass_cnt++;
            end
            push_rx(build_pkt(2'd2, 2'd0, 3'(i), 32'(i + 1)));
        end
        total_cnt++; if (next_full_local !== 1'b1) $display("FAIL full nf_at6 got %0b want 1", next_full_local); else pass_cnt++;
        push_rx(build_pkt(2'd2, 2'd0, 3'd6, 32'd7));
        push_rx(build_pkt(2'd2, 2'd0, 3'd7, 32'd8));
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL full drop_at8 got %0d want 0", drop_count); else pass_cnt++;
        total_cnt++; if (rx_count !== 16'd8) $display("FAIL full rx_count_at8 got %0d want 8", rx_count); else pass_cnt++;
        push_rx(build_pkt(2'd2, 2'd0, 3'd0, 32'd9));
        total_cnt++; if (drop_count !== 8'd1) $display("FAIL full drop_at9 got %0d want 1", drop_count); else pass_cnt++;
        total_cnt++; if (rx_count !== 16'd8) $display("FAIL full rx_count_at9 got %0d want 8", rx_count); else pass_cnt++;
        total_cnt++; if (rx_payload !== 32'd1) $display("FAIL full head got %0d want 1", rx_payload); else pass_cnt++;
        rx_ready = 1'b1;
        push_rx(build_pkt(2'd2, 2'd0, 3'd1, 32'd10));
        rx_ready = 1'b0;
        total_cnt++; if (rx_count !== 16'd9 || drop_count !== 8'd1)
            $display("FAIL full push_pop got rx=%0d drop=%0d want 9/1", rx_count, drop_count); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if (rx_valid !== 1'b1 || rx_payload !== exp_pay[i])
                $display("FAIL full drain%0d got v=%0b pay=%0d want 1/%0d", i, rx_valid, rx_payload, exp_pay[i]); else pass_cnt++;
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        total_cnt++; if (rx_valid !== 1'b0 || next_full_local !== 1'b0 || seq_err !== 1'b0)
            $display("FAIL full drained got v=%0b nf=%0b se=%0b want 000", rx_valid, next_full_local, seq_err); else pass_cnt++;
    endtask

    task automatic test_seq_err();
        do_reset();
        rx_ready = 1'b1;
        push_rx(build_pkt(2'd2, 2'd0, 3'd0, 32'hA));
        total_cnt++; if (seq_err !== 1'b0) $display("FAIL seq in_order got %0b want 0", seq_err); else pass_cnt++;
        push_rx(build_pkt(2'd2, 2'd0, 3'd2, 32'hB));
        total_cnt++; if (seq_err !== 1'b1) $display("FAIL seq gap got %0b want 1", seq_err); else pass_cnt++;
        push_rx(build_pkt(2'd2, 2'd0, 3'd3, 32'hC));
        push_rx(build_pkt(2'd2, 2'd0, 3'd4, 32'hD));
        total_cnt++; if (seq_err !== 1'b1) $display("FAIL seq sticky got %0b want 1", seq_err); else pass_cnt++;
        total_cnt++; if (rx_count !== 16'd4) $display("FAIL seq rx_count got %0d want 4", rx_count); else pass_cnt++;
        do_reset();
        total_cnt++; if (seq_err !== 1'b0) $display("FAIL seq cleared got %0b want 0", seq_err); else pass_cnt++;
    endtask

    task automatic test_drop_saturate();
        do_reset();
        data_to_local = 40'h80_0000_0000;
        wr_next_local_en = 1'b1;
        repeat (260) tick();
        wr_next_local_en = 1'b0;
        data_to_local = '0;
        total_cnt++; if (drop_count !== 8'd255) $display("FAIL sat drop_count got %0d want 255", drop_count); else pass_cnt++;
        total_cnt++; if (rx_count !== 16'd0 || rx_valid !== 1'b0)
            $display("FAIL sat rx got cnt=%0d v=%0b want 0/0", rx_count, rx_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_tx_back_to_back();
        test_tx_backpressure();
        test_rx_filter();
        test_rx_full();
        test_seq_err();
        test_drop_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
